wb_arbiter: RTL and testbench

//  Write-side master for the 32x32 register file: merges ALU, load and mul/div results onto the single write port.

---
 rtl/wb_arbiter_if.sv | 37 +++
 rtl/wb_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Result-bus interface between the execute/memory units and the write-back arbiter.
// The master modport is the arbiter's view; slave is the producers'/regfile's view.
interface wb_arbiter_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              ld_ready;
  logic              md_valid;
  logic [REG_AW-1:0] md_rd;
  logic [XLEN-1:0]   md_data;
  logic              md_ready;
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  modport master (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  md_valid, md_rd, md_data,
    output ld_ready, md_ready,
    output wb_en, wb_rd, wb_data
  );

  modport slave (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output md_valid, md_rd, md_data,
    input  ld_ready, md_ready,
    input  wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter (ALU > round-robin load/muldiv) with pending-write scoreboard.
// Optional WB_BYPASS_EN: forward the in-flight write to the issue stage instead of stalling.
module wb_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1_index,
  input  logic [REG_AW-1:0] rs2_index,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rs1_fwd_valid,
  output logic [XLEN-1:0]   rs1_fwd_data,
  output logic              rs2_fwd_valid,
  output logic [XLEN-1:0]   rs2_fwd_data,
  wb_arbiter_if.master      bus
);
  localparam int unsigned NREG = 2 ** REG_AW;

  typedef enum logic {RR_LD = 1'b0, RR_MD = 1'b1} rr_t;

  rr_t               rr_q, rr_d;
  logic [NREG-1:0]   sb_q, sb_d;
  logic              sel_valid;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              rs1_hit, rs2_hit;

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) rr_q <= RR_LD;
    else     rr_q <= rr_d;
  end

  // Grant logic: ALU pre-empts; pointer only matters (and only moves) when ld and md contend
  always_comb begin
    rr_d         = rr_q;
    bus.ld_ready = 1'b0;
    bus.md_ready = 1'b0;
    if (!rst && !bus.alu_valid) begin
      if (bus.ld_valid && bus.md_valid) begin
        if (rr_q == RR_LD) begin
          bus.ld_ready = 1'b1;
          rr_d         = RR_MD;
        end else begin
          bus.md_ready = 1'b1;
          rr_d         = RR_LD;
        end
      end else begin
        bus.ld_ready = bus.ld_valid;
        bus.md_ready = bus.md_valid;
      end
    end
  end

  // Write-port mux of the accepted result
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.alu_rd;
      sel_data  = bus.alu_data;
    end else if (bus.ld_ready) begin
      sel_valid = 1'b1;
      sel_rd    = bus.ld_rd;
      sel_data  = bus.ld_data;
    end else if (bus.md_ready) begin
      sel_valid = 1'b1;
      sel_rd    = bus.md_rd;
      sel_data  = bus.md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_en   <= 1'b0;
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
    end else begin
      bus.wb_en <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        bus.wb_rd   <= sel_rd;
        bus.wb_data <= sel_data;
      end
    end
  end

  // Scoreboard: completions clear first so a same-edge issue to that rd wins
  always_comb begin
    sb_d = sb_q;
    if (bus.ld_ready) sb_d[bus.ld_rd] = 1'b0;
    if (bus.md_ready) sb_d[bus.md_rd] = 1'b0;
    if (issue_en && (issue_rd != '0)) sb_d[issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  assign rs1_hit = bus.wb_en && (bus.wb_rd == rs1_index) && (rs1_index != '0);
  assign rs2_hit = bus.wb_en && (bus.wb_rd == rs2_index) && (rs2_index != '0);

`ifdef WB_BYPASS_EN
  assign rs1_busy      = (rs1_index != '0) && sb_q[rs1_index];
  assign rs2_busy      = (rs2_index != '0) && sb_q[rs2_index];
  assign rs1_fwd_valid = rs1_hit;
  assign rs2_fwd_valid = rs2_hit;
  assign rs1_fwd_data  = rs1_hit ? bus.wb_data : '0;
  assign rs2_fwd_data  = rs2_hit ? bus.wb_data : '0;
`else
  // The regfile write lands at the end of this cycle, so an in-flight hit stalls once
  assign rs1_busy      = ((rs1_index != '0) && sb_q[rs1_index]) || rs1_hit;
  assign rs2_busy      = ((rs2_index != '0) && sb_q[rs2_index]) || rs2_hit;
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: per-cycle model of grants/scoreboard,
// expected write-back pushed to a queue at drive time and popped after the edge.
module tb_wb_arbiter;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic              en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              full;
  } wb_exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_en;
  logic [REG_AW-1:0] issue_rd;
  logic [REG_AW-1:0] rs1_index;
  logic [REG_AW-1:0] rs2_index;
  logic              rs1_busy, rs2_busy;
  logic              rs1_fwd_valid, rs2_fwd_valid;
  logic [XLEN-1:0]   rs1_fwd_data, rs2_fwd_data;

  wb_arbiter_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_en      (issue_en),
    .issue_rd      (issue_rd),
    .rs1_index     (rs1_index),
    .rs2_index     (rs2_index),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs2_fwd_data  (rs2_fwd_data),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  wb_exp_t           exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  logic [31:0]       m_sb = '0;
  logic              m_rr = 1'b0;
  logic              m_en = 1'b0;
  logic [REG_AW-1:0] m_rd = '0;
  logic [XLEN-1:0]   m_data = '0;
  logic              last_ld_grant, last_md_grant;
  logic              grants[4];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic exp_busy(input logic [REG_AW-1:0] rs);
    return (rs != '0) && (m_sb[rs] || (!BYP && m_en && m_rd == rs));
  endfunction

  function automatic logic exp_fwd(input logic [REG_AW-1:0] rs);
    return BYP && (rs != '0) && m_en && (m_rd == rs);
  endfunction

  task automatic clear_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.md_valid  = 1'b0; bus.md_rd  = '0; bus.md_data  = '0;
    issue_en = 1'b0; issue_rd = '0; rs1_index = '0; rs2_index = '0;
  endtask

  // One cycle: check combinational outputs, predict the write-back, clock, compare
  task automatic step();
    logic    e_ld, e_md;
    wb_exp_t e, got;
    #1;
    e_ld = 1'b0;
    e_md = 1'b0;
    if (!rst && !bus.alu_valid) begin
      if (bus.ld_valid && bus.md_valid) begin
        e_ld = (m_rr == 1'b0);
        e_md = (m_rr == 1'b1);
      end else begin
        e_ld = bus.ld_valid;
        e_md = bus.md_valid;
      end
    end
    check("ld_ready", 64'(bus.ld_ready), 64'(e_ld));
    check("md_ready", 64'(bus.md_ready), 64'(e_md));
    if (!rst) begin
      check("rs1_busy", 64'(rs1_busy), 64'(exp_busy(rs1_index)));
      check("rs2_busy", 64'(rs2_busy), 64'(exp_busy(rs2_index)));
      check("rs1_fwd_valid", 64'(rs1_fwd_valid), 64'(exp_fwd(rs1_index)));
      check("rs2_fwd_valid", 64'(rs2_fwd_valid), 64'(exp_fwd(rs2_index)));
      if (exp_fwd(rs1_index)) check("rs1_fwd_data", 64'(rs1_fwd_data), 64'(m_data));
      if (exp_fwd(rs2_index)) check("rs2_fwd_data", 64'(rs2_fwd_data), 64'(m_data));
    end

    e = '{en: 1'b0, rd: '0, data: '0, full: 1'b0};
    if (rst) begin
      e.full = 1'b1;
    end else if (bus.alu_valid) begin
      e.en = (bus.alu_rd != '0); e.rd = bus.alu_rd; e.data = bus.alu_data;
    end else if (e_ld) begin
      e.en = (bus.ld_rd != '0);  e.rd = bus.ld_rd;  e.data = bus.ld_data;
    end else if (e_md) begin
      e.en = (bus.md_rd != '0);  e.rd = bus.md_rd;  e.data = bus.md_data;
    end
    exp_q.push_back(e);
    last_ld_grant = e_ld;
    last_md_grant = e_md;

    if (rst) begin
      m_sb = '0;
      m_rr = 1'b0;
    end else begin
      if (e_ld) m_sb[bus.ld_rd] = 1'b0;
      if (e_md) m_sb[bus.md_rd] = 1'b0;
      if (issue_en && issue_rd != '0) m_sb[issue_rd] = 1'b1;
      if (bus.ld_valid && bus.md_valid && !bus.alu_valid) m_rr = ~m_rr;
    end

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("wb_en", 64'(bus.wb_en), 64'(got.en));
    if (got.en || got.full) begin
      check("wb_rd", 64'(bus.wb_rd), 64'(got.rd));
      check("wb_data", 64'(bus.wb_data), 64'(got.data));
    end
    m_en   = got.en;
    m_rd   = got.rd;
    m_data = got.data;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd5; bus.ld_data = 32'hDEAD;
    step();
    step();
    rst = 1'b0;
    clear_inputs();

    // ALU write, one-cycle latency, one-cycle pulse
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    step();
    check("alu_wb_data", 64'(bus.wb_data), 64'h1234);
    clear_inputs();
    step();
    check("alu_wb_pulse", 64'(bus.wb_en), 64'h0);

    // Pending load makes rs1 busy until its result is written
    issue_en = 1'b1; issue_rd = 5'd7; rs1_index = 5'd7;
    step();
    check("raw_busy", 64'(rs1_busy), 64'h1);
    clear_inputs();
    rs1_index = 5'd7;
    step();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'hAA;
    step();
    check("ld_wb_data", 64'(bus.wb_data), 64'hAA);
    clear_inputs();
    rs1_index = 5'd7;
    step();
    step();

    // ALU pre-empts a waiting load; load goes next cycle
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd4; bus.ld_data  = 32'h22;
    step();
    bus.alu_valid = 1'b0;
    step();
    check("ld_after_alu_rd", 64'(bus.wb_rd), 64'd4);
    clear_inputs();
    step();

    // Contended ld/md: round-robin starting with load
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_data = 32'h100;
    bus.md_valid = 1'b1; bus.md_rd = 5'd12; bus.md_data = 32'h200;
    for (int k = 0; k < 4; k++) begin
      step();
      grants[k] = last_ld_grant;
      if (last_ld_grant) bus.ld_data = bus.ld_data + 32'h1;
      if (last_md_grant) bus.md_data = bus.md_data + 32'h1;
    end
    check("rr_grant0_ld", 64'(grants[0]), 64'h1);
    check("rr_grant1_md", 64'(grants[1]), 64'h0);
    check("rr_grant2_ld", 64'(grants[2]), 64'h1);
    check("rr_grant3_md", 64'(grants[3]), 64'h0);
    clear_inputs();
    step();

    // rd==0 result consumed without a write
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hFFFF;
    step();
    check("rd0_no_wb", 64'(bus.wb_en), 64'h0);
    clear_inputs();

    // Same-edge issue and completion on rd 3: set wins
    issue_en = 1'b1; issue_rd = 5'd3;
    step();
    clear_inputs();
    bus.md_valid = 1'b1; bus.md_rd = 5'd3; bus.md_data = 32'h33;
    issue_en = 1'b1; issue_rd = 5'd3; rs2_index = 5'd3;
    step();
    check("sb_set_wins", 64'(rs2_busy), 64'h1);
    clear_inputs();
    rs2_index = 5'd3;
    step();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'h44;
    step();
    clear_inputs();
    issue_en = 1'b1; issue_rd = 5'd0;
    step();
    clear_inputs();
    rs2_index = 5'd3;
    step();

    // In-flight write to x9 seen by rs2, then reset while it is in flight
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h55;
    issue_en = 1'b1; issue_rd = 5'd11;
    step();
    check("inflight_rd9", 64'(bus.wb_rd), 64'd9);
    clear_inputs();
    rs2_index = 5'd9; rs1_index = 5'd11;
    step();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h56;
    step();
    clear_inputs();
    rs2_index = 5'd9;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rs1_index = 5'd11; rs2_index = 5'd9;
    step();
    check("rst_rs1_busy", 64'(rs1_busy), 64'h0);
    check("rst_rs2_busy", 64'(rs2_busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
